// File: rtl/board_state_generator_pkg.sv
// Shared types, cell bit layout and neighbour-count helper for the minesweeper board.
package board_pkg;

  localparam int unsigned N       = 8;
  localparam int unsigned CNT_LSB = 0;
  localparam int unsigned MINE_B  = 4;
  localparam int unsigned REV_B   = 5;
  localparam int unsigned FLAG_B  = 6;
  localparam int unsigned CUR_B   = 7;

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, PLAY, LOST, WON} gstate_t;
  typedef logic [11:0] cell_t;

  // Sum of mine bits of the in-bounds 8-neighbours of cell idx (row*8+col).
  function automatic logic [3:0] nbr_count(input logic [63:0] mines, input logic [5:0] idx);
    logic [3:0] sum;
    logic [5:0] ni;
    int r;
    int c;
    sum = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        r  = int'(idx[5:3]) + int'(dr) - 1;
        c  = int'(idx[2:0]) + int'(dc) - 1;
        ni = 6'(r * int'(N) + c);
        if (!(dr == 1 && dc == 1) && r >= 0 && r < int'(N) && c >= 0 && c < int'(N))
          sum = sum + {3'b000, mines[ni]};
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/board_state_generator_if.sv
// Game control inputs and board/status outputs between the game logic and its driver.
interface board_state_generator_if;
  import board_pkg::*;

  logic [5:0]         bombs;
  logic               start;
  logic [2:0]         cur_row;
  logic [2:0]         cur_col;
  logic               reveal;
  logic               flag;
  cell_t [7:0][7:0]   board;
  logic               ready;
  logic               lost;
  logic               won;

  modport master (output bombs, start, cur_row, cur_col, reveal, flag,
                  input  board, ready, lost, won);
  modport slave  (input  bombs, start, cur_row, cur_col, reveal, flag,
                  output board, ready, lost, won);
endinterface

// File: rtl/board_state_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/board_state_generator.sv
// Minesweeper game state: mine placement, neighbour counts, reveal/flag tracking, win/lose.
module board_state_generator
  import board_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  board_state_generator_if.slave  bus
);

  logic [15:0]      lfsr;
  gstate_t          state;
  logic [63:0]      mine;
  logic [63:0]      rev;
  logic [63:0]      flg;
  logic [63:0][3:0] cnt;
  logic [5:0]       target;
  logic [5:0]       placed;
  logic [5:0]       probe;
  logic [5:0]       idx;
  logic [6:0]       rcnt;
  logic [6:0]       need;
  logic [5:0]       cur;
  logic             ready;
  logic             lost;
  logic             won;
  logic             unused_lfsr_hi;

  lfsr16 #(.SEED(SEED)) u_lfsr (.CLOCK_50(CLOCK_50), .reset(reset), .q(lfsr));

  assign unused_lfsr_hi = ^lfsr[15:6];
  assign cur  = {bus.cur_row, bus.cur_col};
  assign need = 7'd64 - {1'b0, target};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mine   <= '0;
      rev    <= '0;
      flg    <= '0;
      cnt    <= '0;
      target <= '0;
      placed <= '0;
      probe  <= '0;
      idx    <= '0;
      rcnt   <= '0;
      ready  <= 1'b0;
      lost   <= 1'b0;
      won    <= 1'b0;
    end else if (bus.start) begin
      state  <= CLEAR;
      target <= bus.bombs;
      mine   <= '0;
      rev    <= '0;
      flg    <= '0;
      cnt    <= '0;
      rcnt   <= '0;
      ready  <= 1'b0;
      lost   <= 1'b0;
      won    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CLEAR: begin
          mine   <= '0;
          rev    <= '0;
          flg    <= '0;
          cnt    <= '0;
          placed <= '0;
          probe  <= lfsr[5:0];
          idx    <= '0;
          rcnt   <= '0;
          state  <= PLACE;
        end
        PLACE: begin
          if (placed == target) begin
            idx   <= '0;
            state <= COUNT;
          end else if (!mine[probe]) begin
            mine[probe] <= 1'b1;
            placed      <= placed + 6'd1;
            probe       <= lfsr[5:0];
          end else begin
            probe <= probe + 6'd1;
          end
        end
        COUNT: begin
          cnt[idx] <= nbr_count(mine, idx);
          idx      <= idx + 6'd1;
          if (idx == 6'd63) begin
            state <= PLAY;
            ready <= 1'b1;
          end
        end
        PLAY: begin
          // reveal takes priority; a simultaneous flag is dropped
          if (bus.reveal) begin
            if (!rev[cur] && !flg[cur]) begin
              if (mine[cur]) begin
                rev   <= rev | mine;
                state <= LOST;
                lost  <= 1'b1;
                ready <= 1'b0;
              end else begin
                rev[cur] <= 1'b1;
                rcnt     <= rcnt + 7'd1;
                if (rcnt + 7'd1 == need) begin
                  state <= WON;
                  won   <= 1'b1;
                  ready <= 1'b0;
                end
              end
            end
          end else if (bus.flag && !rev[cur]) begin
            flg[cur] <= ~flg[cur];
          end
        end
        LOST: ;
        WON: ;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int K = r * 8 + c;
      assign bus.board[r][c] = cell_t'({cur == 6'(K), flg[K], rev[K], mine[K], cnt[K]});
    end
  end

  assign bus.ready = ready;
  assign bus.lost  = lost;
  assign bus.won   = won;

endmodule

// File: tb/tb_board_state_generator.sv
// Scoreboard bench: spec-level game model predicts board/status; a negedge monitor checks them.
module tb_board_state_generator;
  import board_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  board_state_generator_if bus();

  board_state_generator #(.SEED(SEED)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // rising edges seen since reset was released
  int ecount = 0;
  always @(posedge CLOCK_50 or posedge reset)
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;

  typedef struct {
    int               at;
    string            name;
    bit               rdy;
    bit               lst;
    bit               wn;
    bit               chk_board;
    logic [63:0][6:0] cells;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [63:0]      m_mine;
  logic [63:0]      m_rev;
  logic [63:0]      m_flag;
  logic [63:0][3:0] m_cnt;
  int               m_target;
  int               m_rcnt;
  int               m_st;     // 0 play, 1 lost, 2 won

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] lstep(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic exp_t snap(int at, string name, bit chk_board);
    exp_t e;
    e.at = at; e.name = name; e.chk_board = chk_board;
    e.rdy = (m_st == 0); e.lst = (m_st == 1); e.wn = (m_st == 2);
    for (int i = 0; i < 64; i++)
      e.cells[6'(i)] = {m_flag[6'(i)], m_rev[6'(i)], m_mine[6'(i)], m_cnt[6'(i)]};
    return e;
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if ((bus.board[3'(r)][3'(c)] & 12'hF7F) != 12'h000) n++;
    return n;
  endfunction

  function automatic int count_mines();
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (bus.board[3'(r)][3'(c)][MINE_B]) n++;
    return n;
  endfunction

  function automatic int pick(bit want_mine);
    int s = int'($urandom_range(63, 0));
    logic [5:0] p;
    for (int i = 0; i < 64; i++) begin
      p = 6'(s + i);
      if (m_mine[p] == want_mine && !m_rev[p] && !m_flag[p]) return int'(p);
    end
    return 0;
  endfunction

  always @(negedge CLOCK_50) begin : monitor
    exp_t  e;
    cell_t a;
    int    bad;
    int    first;
    while (!reset && exp_q.size() > 0 && exp_q[0].at <= ecount) begin
      e = exp_q.pop_front();
      check({e.name, ".ready"}, int'(bus.ready), int'(e.rdy));
      check({e.name, ".lost"},  int'(bus.lost),  int'(e.lst));
      check({e.name, ".won"},   int'(bus.won),   int'(e.wn));
      if (e.chk_board) begin
        bad = 0; first = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            a = bus.board[3'(r)][3'(c)];
            if ({a[11:8], a[6:0]} != {4'b0000, e.cells[6'(r * 8 + c)]}) begin
              if (bad == 0) first = r * 8 + c;
              bad++;
            end
          end
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL %s.board: %0d cells differ, first cell %0d got %h expected %h",
                   e.name, bad, first, bus.board[3'(first / 8)][3'(first % 8)] & 12'hF7F,
                   {5'b00000, e.cells[6'(first)]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic wait_edge(int at);
    int g = 0;
    while (ecount < at && g < 5000) begin tick(); g++; end
    if (ecount < at) check("wait_timeout", ecount, at);
    #5;
  endtask

  // Placement per the game rules: the LFSR value used at rising edge E is SEED stepped E-1 times.
  task automatic model_place(int k, int b, output int att);
    logic [15:0] v;
    logic [5:0]  p;
    int placed, s, rr, cc;
    m_mine = '0; m_rev = '0; m_flag = '0; m_cnt = '0;
    m_target = b; m_rcnt = 0; m_st = 0;
    v = SEED;
    repeat (k) v = lstep(v);
    p = v[5:0]; placed = 0; att = 0;
    forever begin
      v = lstep(v);
      if (placed == b) break;
      if (!m_mine[p]) begin m_mine[p] = 1'b1; placed++; p = v[5:0]; end
      else p = p + 6'd1;
      att++;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr; cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              s += int'(m_mine[6'(rr * 8 + cc)]);
          end
        m_cnt[6'(r * 8 + c)] = 4'(s);
      end
  endtask

  task automatic launch(int b, output int k, output int att);
    bus.bombs = 6'(b); bus.start = 1'b1;
    k = ecount + 1;
    tick();
    bus.start = 1'b0;
    model_place(k, b, att);
  endtask

  task automatic expect_ready(int k, int att, string name);
    exp_t e;
    e = snap(k + 65 + att, {name, ".pre_ready"}, 1'b0);
    e.rdy = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(snap(k + 66 + att, {name, ".ready"}, 1'b1));
    wait_edge(k + 66 + att);
  endtask

  task automatic play_ready(int b, string name);
    int k, att;
    launch(b, k, att);
    expect_ready(k, att, name);
  endtask

  task automatic act(int idx, bit rv, bit fl, string name);
    int at;
    logic [5:0] p;
    p = 6'(idx);
    bus.cur_row = p[5:3]; bus.cur_col = p[2:0];
    bus.reveal = rv; bus.flag = fl;
    at = ecount + 1;
    tick();
    bus.reveal = 1'b0; bus.flag = 1'b0;
    if (m_st == 0) begin
      if (rv) begin
        if (!m_rev[p] && !m_flag[p]) begin
          if (m_mine[p]) begin m_st = 1; m_rev = m_rev | m_mine; end
          else begin
            m_rev[p] = 1'b1; m_rcnt++;
            if (m_rcnt == 64 - m_target) m_st = 2;
          end
        end
      end else if (fl && !m_rev[p]) m_flag[p] = ~m_flag[p];
    end
    exp_q.push_back(snap(at, name, 1'b1));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int order[64];
    int k, att, idx, j, tmp, n;
    exp_t e;
    bus.bombs = '0; bus.start = 1'b0; bus.cur_row = '0; bus.cur_col = '0;
    bus.reveal = 1'b0; bus.flag = 1'b0;
    #13;
    check("reset.ready", int'(bus.ready), 0);
    check("reset.lost",  int'(bus.lost),  0);
    check("reset.won",   int'(bus.won),   0);
    check("reset.board_nonzero_cells", count_nonzero(), 0);
    @(negedge CLOCK_50); reset = 1'b0;
    tick();

    // empty board: ready timing, cursor, reveal every cell to win
    play_ready(0, "g0");
    bus.cur_row = 3'd5; bus.cur_col = 3'd2; #1;
    check("cursor.on",  int'(bus.board[5][2][CUR_B]), 1);
    check("cursor.off", int'(bus.board[2][5][CUR_B]), 0);
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 64; i++) act(order[i], 1'b1, 1'b0, $sformatf("g0.rev%0d", i));
    act(0, 1'b1, 1'b0, "g0.won_ignores_reveal");
    act(1, 1'b0, 1'b1, "g0.won_ignores_flag");

    // ten mines: counts, flag rules, losing
    play_ready(10, "g10");
    check("g10.mine_count", count_mines(), 10);
    act(19, 1'b0, 1'b1, "g10.flag_on");
    act(19, 1'b1, 1'b0, "g10.reveal_flagged");
    act(19, 1'b0, 1'b1, "g10.flag_off");
    act(pick(1'b0), 1'b1, 1'b1, "g10.reveal_and_flag");
    repeat (6) begin
      idx = int'($urandom_range(63, 0));
      if (m_mine[6'(idx)]) act(idx, 1'b0, 1'b1, "g10.rand_flag");
      else                 act(idx, 1'b1, 1'b0, "g10.rand_reveal");
    end
    act(pick(1'b1), 1'b1, 1'b0, "g10.reveal_mine");
    act(pick(1'b0), 1'b1, 1'b0, "g10.lost_ignores_reveal");

    // nearly full board: single safe cell wins
    play_ready(63, "g63");
    check("g63.mine_count", count_mines(), 63);
    idx = pick(1'b0);
    n = int'(bus.board[3'(idx / 8)][3'(idx % 8)][3:0]);
    check("g63.safe_count_in_range", int'(n >= 3 && n <= 8), 1);
    act(idx, 1'b1, 1'b0, "g63.reveal_last");

    // restart from PLAY clears the board
    play_ready(20, "g20");
    launch(0, k, att);
    e = snap(k + 1, "restart.cleared", 1'b1);
    e.rdy = 1'b0;
    exp_q.push_back(e);
    expect_ready(k, att, "restart");

    // asynchronous reset mid-COUNT
    launch(10, k, att);
    wait_edge(k + 2 + att + 20);
    check("pre_reset.board_populated", int'(count_nonzero() > 0), 1);
    #2; reset = 1'b1; #1;
    check("reset_count.board_nonzero_cells", count_nonzero(), 0);
    check("reset_count.ready", int'(bus.ready), 0);
    @(negedge CLOCK_50); reset = 1'b0;
    tick();

    // asynchronous reset during PLAY drops ready without an edge
    play_ready(5, "g5");
    #2; reset = 1'b1; #1;
    check("reset_play.ready", int'(bus.ready), 0);
    check("reset_play.board_nonzero_cells", count_nonzero(), 0);
    @(negedge CLOCK_50); reset = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_state_generator.md
# board_state_generator

Game-state source for the 8x8 minesweeper display. It places `bombs` mines pseudo-randomly and computes each cell's neighbour-mine count. It then tracks reveal/flag actions and the win/lose outcome. Its `board` output array feeds the VGA board controller directly, one 12-bit code per cell, indexed `[row][col]`.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value; must be non-zero.
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `bombs`, in, 6: requested mine count 0–63; sampled on `start`.
- `start`, in, 1: single-cycle pulse; begins a new game from any state.
- `cur_row`, in, 3: cursor row.
- `cur_col`, in, 3: cursor column.
- `reveal`, in, 1: single-cycle pulse; reveal the cursor cell.
- `flag`, in, 1: single-cycle pulse; toggle the flag on the cursor cell.
- `board`, out, 12 x [7:0][7:0]: per-cell display code.
- `ready`, out, 1: high while in PLAY.
- `lost`, out, 1: high in LOST.
- `won`, out, 1: high in WON.

## Operation
- Cell code bits:
  - [3:0] neighbour count, 0–8.
  - [4] mine.
  - [5] revealed.
  - [6] flagged.
  - [7] cursor; combinational, set when row/col equals `cur_row`/`cur_col`.
  - [11:8] always 0.
- Reset values: all cell state 0, `ready`/`lost`/`won` = 0, state IDLE, LFSR = `SEED`, counters 0.
- The LFSR runs every cycle, including IDLE. It is a 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting left; the new bit enters at [0].
- FSM states and transitions:
  - IDLE: wait for `start`.
  - CLEAR: one cycle. Zero all cell state, latch `target = bombs`, `placed = 0`, load `probe = lfsr[5:0]`.
  - PLACE: one attempt per cycle.
    - If `placed == target`, go to COUNT.
    - Else if cell `probe` has no mine: set its mine bit, `placed++`, reload `probe = lfsr[5:0]`.
    - Else (collision): `probe = probe + 1`, wrapping 63 to 0.
    - Each mine is therefore bounded to at most 64 attempts. Cell index = row*8 + col.
  - COUNT: 64 cycles, index 0..63. Write the sum of the mine bits of the in-bounds 8-neighbours (out-of-range rows/columns contribute 0) into [3:0]. Mine cells also get their count written. After index 63, go to PLAY.
  - PLAY: `ready = 1`. Action priority: `start` > `reveal` > `flag`, so `reveal` and `flag` in the same cycle means `flag` is ignored.
    - `reveal` on an unrevealed, unflagged non-mine cell sets [5] and increments `revealed_cnt`.
    - `reveal` on an unrevealed, unflagged mine goes to LOST.
    - `reveal` on a flagged or already-revealed cell does nothing.
    - `flag` on an unrevealed cell toggles [6]; on a revealed cell it does nothing.
    - Go to WON when `revealed_cnt == 64 - target`.
  - LOST: on entry (the same edge as the transition), set [5] on every mine cell. Ignore `reveal`/`flag` until `start`.
  - WON: ignore `reveal`/`flag` until `start`.
- `start` in any state, including mid-PLACE or mid-COUNT, goes to CLEAR on the next edge.
- No flood-fill; each reveal affects one cell only.

## Timing
- `start` sampled at edge k: CLEAR at k+1, PLACE from k+2.
- With `bombs = 0`: PLACE lasts one cycle, COUNT lasts 64, and `ready` rises at edge k+66.
- All outputs are registered except cursor bit [7].
- `lost`/`won` assert one edge after the deciding `reveal`.
- The revealed bit is visible on `board` one edge after `reveal`.
- `reset` assertion zeros all outputs immediately, independent of the clock.
- `revealed_cnt` is 7 bits; `64 - target` is computed at 7 bits and lies in 1..64.

## Structure
- Package `board_pkg`:
  - `N = 8`.
  - Cell bit-position localparams: `CNT_LSB`, `MINE_B`, `REV_B`, `FLAG_B`, `CUR_B`.
  - `typedef enum {IDLE, CLEAR, PLACE, COUNT, PLAY, LOST, WON} gstate_t`.
  - `typedef logic [11:0] cell_t`.
- Sub-module `lfsr16` (parameter `SEED`; ports `CLOCK_50`, `reset`, `q[15:0]`).
- Neighbour-count adder: combinational function in the package, taking the mine plane and an index.

## Test plan
- `bombs = 0`, `start` → `ready` at exactly k+66, all counts 0; reveal all 64 cells one by one → `won = 1` after the 64th.
- `bombs = 10`, `start` → exactly 10 mine bits set; every cell's [3:0] matches the bench model, including corners (0,0) and (7,7).
- `bombs = 63` → exactly one non-mine cell, count in 3..8; reveal it → `won = 1` one edge later.
- Reveal a known mine cell → `lost = 1`, all 63/10 mine cells show [5] = 1; a following `reveal` of a safe cell leaves its [5] = 0.
- `flag` on cell (2,3) → [6] = 1; `reveal` (2,3) → no change; `flag` again → [6] = 0; `reveal` and `flag` in the same cycle → only [5] changes.
- Assert `reset` mid-COUNT → `board` all-zero, `ready` = 0 without a clock edge; `start` during PLAY → `ready` drops at k+1 and the board is cleared.
